// File: rtl/alu_issue_ctrl_if.sv
// -----------------------------------------------------------------------------
// alu_issue_ctrl_if
// Bundle for the alu_issue_ctrl handshake and ALU/writeback buses.
//   in_valid/in_ready/in_instr : instruction input handshake
//   alu_op1/op2/opcode/funct   : registered operands driven to the ALU
//   alu_result/alu_zero        : registered ALU outputs back to the controller
//   wb_valid/wb_addr/wb_data   : writeback (register write) pulse
// Modports:
//   master : the issue controller
//   slave  : the environment (instruction source, ALU, writeback observer)
// -----------------------------------------------------------------------------
interface alu_issue_ctrl_if;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_instr;
   logic [7:0]  alu_op1;
   logic [7:0]  alu_op2;
   logic [3:0]  alu_opcode;
   logic [3:0]  alu_funct;
   logic [7:0]  alu_result;
   logic        alu_zero;
   logic        wb_valid;
   logic [3:0]  wb_addr;
   logic [7:0]  wb_data;

   modport master (
      input  in_valid, in_instr, alu_result, alu_zero,
      output in_ready, alu_op1, alu_op2, alu_opcode, alu_funct,
             wb_valid, wb_addr, wb_data
   );

   modport slave (
      output in_valid, in_instr, alu_result, alu_zero,
      input  in_ready, alu_op1, alu_op2, alu_opcode, alu_funct,
             wb_valid, wb_addr, wb_data
   );
endinterface

// File: rtl/alu_issue_ctrl.sv
// -----------------------------------------------------------------------------
// alu_issue_ctrl
// Issue/writeback sequencer for the registered 8-bit ALU. Accepts one 16-bit
// instruction ([15:12] opcode, [11:8] rd, [7:4] rs, [3:0] funct/imm4), loads
// the ALU operand registers from a 16x8 register file, captures the ALU result
// two edges after accept, then writes back or updates the program counter.
//
// Ports:
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   bus        : alu_issue_ctrl_if.master (handshake, ALU and writeback buses)
//   pc         : retired-instruction program counter (mod 256)
//   halted     : high once a halt (opcode 1100) has retired
//   dbg_addr   : debug register-file read address
//   dbg_data   : combinational register-file read, R0 reads 0
//   dbg_state  : current FSM state (IDLE=0, ISSUE=1, CAPT=2, HALT=3)
//
// Handshake: an instruction transfers on a rising edge where in_valid and
// in_ready are both high; in_ready is registered, high only in IDLE, and
// in_valid is ignored whenever in_ready is low.
//
// Instruction types by opcode:
//   A 0000 : R[rd] <= ALU(R[rd], R[rs])
//   B 10xx : R[rd] <= ALU(R[rd], imm4)
//   C 01xx : branch pc += sext(imm4) when ALU zero, no writeback
//   D 11xx : 1100 halts, others are NOP
//   0001..0011 carry no defined behaviour and retire as NOPs.
// -----------------------------------------------------------------------------
module alu_issue_ctrl (
   input  logic                    clk,
   input  logic                    rst_n,
   alu_issue_ctrl_if.master        bus,
   output logic [7:0]              pc,
   output logic                    halted,
   input  logic [3:0]              dbg_addr,
   output logic [7:0]              dbg_data,
   output logic [1:0]              dbg_state
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_CAPT  = 2'd2,
      S_HALT  = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic        in_ready_q, in_ready_d;
   logic [3:0]  rd_q, rd_d;
   logic [7:0]  op1_q, op1_d;
   logic [7:0]  op2_q, op2_d;
   logic [3:0]  opcode_q, opcode_d;
   logic [3:0]  funct_q, funct_d;
   logic        wb_valid_q, wb_valid_d;
   logic [3:0]  wb_addr_q, wb_addr_d;
   logic [7:0]  wb_data_q, wb_data_d;
   logic [7:0]  pc_q, pc_d;

   logic [7:0]  regs_q [16];
   logic        rf_we;
   logic [3:0]  rf_waddr;
   logic [7:0]  rf_wdata;

   logic [3:0]  in_opc;
   logic [3:0]  in_rd;
   logic [3:0]  in_rs;
   logic [3:0]  in_imm;
   logic [7:0]  rd_val;
   logic [7:0]  rs_val;

   assign in_opc = bus.in_instr[15:12];
   assign in_rd  = bus.in_instr[11:8];
   assign in_rs  = bus.in_instr[7:4];
   assign in_imm = bus.in_instr[3:0];

   // R0 is never written, so a plain array read already returns 0 for it.
   assign rd_val = regs_q[in_rd];
   assign rs_val = regs_q[in_rs];

   // The latched opcode/funct registers double as the retire-time decode.
   always_comb begin
      state_d    = state_q;
      rd_d       = rd_q;
      op1_d      = op1_q;
      op2_d      = op2_q;
      opcode_d   = opcode_q;
      funct_d    = funct_q;
      pc_d       = pc_q;
      wb_valid_d = 1'b0;
      wb_addr_d  = wb_addr_q;
      wb_data_d  = wb_data_q;
      rf_we      = 1'b0;
      rf_waddr   = rd_q;
      rf_wdata   = bus.alu_result;

      case (state_q)
         S_IDLE: begin
            if (bus.in_valid) begin
               rd_d     = in_rd;
               op1_d    = rd_val;
               opcode_d = in_opc;
               funct_d  = in_imm;
               if ((in_opc == 4'b0000) || (in_opc[3:2] == 2'b01)) begin
                  op2_d = rs_val;
               end else if (in_opc[3:2] == 2'b10) begin
                  op2_d = {4'h0, in_imm};
               end else begin
                  op2_d = 8'h00;
               end
               state_d = S_ISSUE;
            end
         end

         // ALU samples alu_op*/alu_opcode/alu_funct at the end of this cycle.
         S_ISSUE: state_d = S_CAPT;

         S_CAPT: begin
            state_d = S_IDLE;
            pc_d    = pc_q + 8'd1;
            if ((opcode_q == 4'b0000) || (opcode_q[3:2] == 2'b10)) begin
               wb_valid_d = 1'b1;
               wb_addr_d  = rd_q;
               wb_data_d  = bus.alu_result;
               // R0 writes still pulse wb_valid but never reach the file.
               rf_we      = (rd_q != 4'd0);
            end else if (opcode_q[3:2] == 2'b01) begin
               if (bus.alu_zero) begin
                  pc_d = pc_q + {{4{funct_q[3]}}, funct_q};
               end
            end else if (opcode_q == 4'b1100) begin
               state_d = S_HALT;
            end
         end

         S_HALT: state_d = S_HALT;

         default: state_d = S_IDLE;
      endcase

      in_ready_d = (state_d == S_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         in_ready_q <= 1'b1;
         rd_q       <= 4'd0;
         op1_q      <= 8'd0;
         op2_q      <= 8'd0;
         opcode_q   <= 4'd0;
         funct_q    <= 4'd0;
         wb_valid_q <= 1'b0;
         wb_addr_q  <= 4'd0;
         wb_data_q  <= 8'd0;
         pc_q       <= 8'd0;
      end else begin
         state_q    <= state_d;
         in_ready_q <= in_ready_d;
         rd_q       <= rd_d;
         op1_q      <= op1_d;
         op2_q      <= op2_d;
         opcode_q   <= opcode_d;
         funct_q    <= funct_d;
         wb_valid_q <= wb_valid_d;
         wb_addr_q  <= wb_addr_d;
         wb_data_q  <= wb_data_d;
         pc_q       <= pc_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 16; i++) begin
            regs_q[i] <= 8'd0;
         end
      end else if (rf_we) begin
         regs_q[rf_waddr] <= rf_wdata;
      end
   end

   assign bus.in_ready   = in_ready_q;
   assign bus.alu_op1    = op1_q;
   assign bus.alu_op2    = op2_q;
   assign bus.alu_opcode = opcode_q;
   assign bus.alu_funct  = funct_q;
   assign bus.wb_valid   = wb_valid_q;
   assign bus.wb_addr    = wb_addr_q;
   assign bus.wb_data    = wb_data_q;

   assign pc        = pc_q;
   assign halted    = (state_q == S_HALT);
   assign dbg_data  = (dbg_addr == 4'd0) ? 8'h00 : regs_q[dbg_addr];
   assign dbg_state = state_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// -----------------------------------------------------------------------------
// tb_alu_issue_ctrl
// Bench for alu_issue_ctrl. A registered ALU model answers the controller; a
// behavioural reference (register array, integer pc, halt flag) predicts every
// retirement. One task per scenario, called in order from a single initial.
// -----------------------------------------------------------------------------
module tb_alu_issue_ctrl;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   alu_issue_ctrl_if bus ();
   logic [7:0] pc;
   logic       halted;
   logic [3:0] dbg_addr;
   logic [7:0] dbg_data;
   logic [1:0] dbg_state;

   alu_issue_ctrl dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .pc        (pc),
      .halted    (halted),
      .dbg_addr  (dbg_addr),
      .dbg_data  (dbg_data),
      .dbg_state (dbg_state)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // ---------------- ALU model (registered, one clock) ----------------
   // Type A: funct F adds, funct 0 returns the undefined code EF, else XOR.
   // Type C: subtract (zero flags equality). Type B: add. Type D: 0.
   function automatic logic [8:0] alu_fn(input logic [3:0] opc, input logic [3:0] fn,
                                         input logic [7:0] a, input logic [7:0] b);
      logic [7:0] r;
      case (opc[3:2])
         2'b00:   r = (fn == 4'hF) ? a + b : ((fn == 4'h0) ? 8'hEF : a ^ b);
         2'b01:   r = a - b;
         2'b10:   r = a + b;
         default: r = 8'h00;
      endcase
      return {(r == 8'h00), r};
   endfunction

   always @(posedge clk) begin
      {bus.alu_zero, bus.alu_result} <= alu_fn(bus.alu_opcode, bus.alu_funct,
                                               bus.alu_op1, bus.alu_op2);
   end

   // ---------------- reference model ----------------
   typedef struct packed {
      logic [7:0] op1;
      logic [7:0] op2;
      logic [3:0] opcode;
      logic [3:0] funct;
      logic       ready_issue;
      logic       ready_capt;
      logic       wb_mid;
      logic       wb_valid;
      logic [3:0] wb_addr;
      logic [7:0] wb_data;
      logic [7:0] pc;
      logic       halted;
      logic       ready_after;
   } txn_t;

   logic [7:0] reg_m [16];
   int         pc_m;
   bit         halted_m;

   task automatic model_reset();
      for (int i = 0; i < 16; i++) reg_m[i] = 8'h00;
      pc_m     = 0;
      halted_m = 0;
   endtask

   task automatic model_exec(input logic [15:0] instr, output txn_t e);
      logic [3:0] opc, rd, rs, imm;
      logic [8:0] res;
      int         off;
      opc = instr[15:12]; rd = instr[11:8]; rs = instr[7:4]; imm = instr[3:0];
      e = '0;
      e.op1    = reg_m[rd];
      e.opcode = opc;
      e.funct  = imm;
      if (opc == 4'd0 || opc[3:2] == 2'b01) e.op2 = reg_m[rs];
      else if (opc[3:2] == 2'b10)           e.op2 = {4'h0, imm};
      else                                  e.op2 = 8'h00;
      res = alu_fn(opc, imm, e.op1, e.op2);
      off = 1;
      if (opc == 4'd0 || opc[3:2] == 2'b10) begin
         e.wb_valid = 1'b1;
         e.wb_addr  = rd;
         e.wb_data  = res[7:0];
         if (rd != 4'd0) reg_m[rd] = res[7:0];
      end else if (opc[3:2] == 2'b01 && res[8]) begin
         off = (imm >= 8) ? int'(imm) - 16 : int'(imm);
      end else if (opc == 4'b1100) begin
         halted_m = 1;
      end
      pc_m = (pc_m + off + 256) % 256;
      e.pc          = pc_m[7:0];
      e.halted      = halted_m;
      e.ready_after = !halted_m;
   endtask

   // ---------------- driver tasks (called at a negedge) ----------------
   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      bus.in_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      model_reset();
   endtask

   // Presents one instruction and records what the DUT shows in ISSUE, CAPT
   // and the cycle after retire. in_valid stays high with junk during ISSUE
   // and CAPT, which the DUT must ignore.
   task automatic drive_instr(input logic [15:0] instr, output txn_t o);
      int n = 0;
      o = '0;
      while (!bus.in_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      n_checks++;
      if (!bus.in_ready) begin
         n_fail++;
         $display("FAIL accept_timeout: in_ready=%0b after %0d cycles, required 1", bus.in_ready, n);
      end
      bus.in_valid = 1'b1;
      bus.in_instr = instr;
      @(negedge clk);
      bus.in_instr  = 16'($urandom);
      o.op1         = bus.alu_op1;
      o.op2         = bus.alu_op2;
      o.opcode      = bus.alu_opcode;
      o.funct       = bus.alu_funct;
      o.ready_issue = bus.in_ready;
      o.wb_mid      = bus.wb_valid;
      @(negedge clk);
      bus.in_instr  = 16'($urandom);
      o.ready_capt  = bus.in_ready;
      o.wb_mid      = o.wb_mid | bus.wb_valid;
      @(negedge clk);
      bus.in_valid  = 1'b0;
      o.wb_valid    = bus.wb_valid;
      o.wb_addr     = bus.wb_addr;
      o.wb_data     = bus.wb_data;
      o.pc          = pc;
      o.halted      = halted;
      o.ready_after = bus.in_ready;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      txn_t o;
      do_reset();
      drive_instr(16'h8105, o);
      // Asynchronous: values clear without waiting for a clock edge.
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({pc, halted, bus.wb_valid, bus.wb_addr, bus.wb_data} !== 22'h0) begin
         n_fail++;
         $display("FAIL reset_outputs: pc=%h halted=%b wb_valid=%b wb_addr=%h wb_data=%h, required all 0",
                  pc, halted, bus.wb_valid, bus.wb_addr, bus.wb_data);
      end
      n_checks++;
      if ({bus.alu_op1, bus.alu_op2, bus.alu_opcode, bus.alu_funct} !== 24'h0) begin
         n_fail++;
         $display("FAIL reset_alu_ops: op1=%h op2=%h opcode=%h funct=%h, required 0",
                  bus.alu_op1, bus.alu_op2, bus.alu_opcode, bus.alu_funct);
      end
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      @(negedge clk);
      n_checks++;
      if (bus.in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_ready: in_ready=%b, required 1", bus.in_ready);
      end
      for (int a = 0; a < 16; a++) begin
         dbg_addr = 4'(a);
         #1;
         n_checks++;
         if (dbg_data !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_reg R%0d: got %h, required 00", a, dbg_data);
         end
      end
   endtask

   task automatic test_first_write();
      txn_t o;
      do_reset();
      drive_instr(16'h8105, o);
      n_checks++;
      if ({o.wb_valid, o.wb_addr, o.wb_data, o.pc} !== {1'b1, 4'd1, 8'h05, 8'd1}) begin
         n_fail++;
         $display("FAIL first_write: wb_valid=%b addr=%h data=%h pc=%h, required 1/1/05/01",
                  o.wb_valid, o.wb_addr, o.wb_data, o.pc);
      end
      dbg_addr = 4'd1;
      #1;
      n_checks++;
      if (dbg_data !== 8'h05) begin
         n_fail++;
         $display("FAIL first_write_dbg: R1=%h, required 05", dbg_data);
      end
   endtask

   task automatic test_back_to_back();
      txn_t o;
      logic [15:0] prog [3];
      prog[0] = 16'h8105; prog[1] = 16'h8203; prog[2] = 16'h012F;
      do_reset();
      for (int i = 0; i < 3; i++) begin
         drive_instr(prog[i], o);
         n_checks++;
         if ({o.ready_issue, o.ready_capt, o.ready_after} !== 3'b001) begin
            n_fail++;
            $display("FAIL b2b_ready[%0d]: issue/capt/after=%b%b%b, required 001",
                     i, o.ready_issue, o.ready_capt, o.ready_after);
         end
      end
      n_checks++;
      if ({o.wb_valid, o.wb_addr, o.wb_data, o.pc} !== {1'b1, 4'd1, 8'h08, 8'd3}) begin
         n_fail++;
         $display("FAIL b2b_add: wb_valid=%b addr=%h data=%h pc=%h, required 1/1/08/03",
                  o.wb_valid, o.wb_addr, o.wb_data, o.pc);
      end
   endtask

   task automatic test_branch();
      txn_t o;
      do_reset();
      drive_instr(16'h8105, o);
      drive_instr(16'h8205, o);
      drive_instr(16'h612E, o);
      n_checks++;
      if ({o.wb_valid, o.wb_mid, o.pc} !== {1'b0, 1'b0, 8'd0}) begin
         n_fail++;
         $display("FAIL branch_taken: wb_valid=%b pc=%h, required 0/00", o.wb_valid, o.pc);
      end
      do_reset();
      drive_instr(16'h8105, o);
      drive_instr(16'h8203, o);
      drive_instr(16'h612E, o);
      n_checks++;
      if ({o.wb_valid, o.pc} !== {1'b0, 8'd3}) begin
         n_fail++;
         $display("FAIL branch_not_taken: wb_valid=%b pc=%h, required 0/03", o.wb_valid, o.pc);
      end
      // R0==R0 with offset -1 from pc 0 wraps to 255, then +1 wraps to 0.
      do_reset();
      drive_instr(16'h600F, o);
      n_checks++;
      if (o.pc !== 8'hFF) begin
         n_fail++;
         $display("FAIL branch_wrap_down: pc=%h, required ff", o.pc);
      end
      drive_instr(16'h8105, o);
      n_checks++;
      if (o.pc !== 8'h00) begin
         n_fail++;
         $display("FAIL pc_wrap_up: pc=%h, required 00", o.pc);
      end
   endtask

   task automatic test_r0_and_undefined();
      txn_t o;
      do_reset();
      drive_instr(16'h8007, o);
      dbg_addr = 4'd0;
      #1;
      n_checks++;
      if ({o.wb_valid, o.wb_addr, o.wb_data, dbg_data} !== {1'b1, 4'd0, 8'h07, 8'h00}) begin
         n_fail++;
         $display("FAIL r0_write: wb_valid=%b addr=%h data=%h R0=%h, required 1/0/07/00",
                  o.wb_valid, o.wb_addr, o.wb_data, dbg_data);
      end
      drive_instr(16'h8103, o);
      drive_instr(16'h0120, o);
      dbg_addr = 4'd1;
      #1;
      n_checks++;
      if ({o.wb_data, dbg_data} !== {8'hEF, 8'hEF}) begin
         n_fail++;
         $display("FAIL undefined_result: wb_data=%h R1=%h, required ef/ef", o.wb_data, dbg_data);
      end
   endtask

   task automatic test_halt();
      txn_t o;
      do_reset();
      drive_instr(16'h8105, o);
      drive_instr(16'hC000, o);
      n_checks++;
      if ({o.pc, o.halted, o.ready_after, o.wb_valid} !== {8'd2, 1'b1, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL halt_retire: pc=%h halted=%b ready=%b wb_valid=%b, required 02/1/0/0",
                  o.pc, o.halted, o.ready_after, o.wb_valid);
      end
      bus.in_valid = 1'b1;
      for (int c = 0; c < 20; c++) begin
         bus.in_instr = 16'h8105;
         @(negedge clk);
         n_checks++;
         if ({bus.in_ready, halted, bus.wb_valid, pc} !== {1'b0, 1'b1, 1'b0, 8'd2}) begin
            n_fail++;
            $display("FAIL halt_hold[%0d]: ready=%b halted=%b wb_valid=%b pc=%h, required 0/1/0/02",
                     c, bus.in_ready, halted, bus.wb_valid, pc);
         end
      end
      bus.in_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({halted, pc} !== {1'b0, 8'd0}) begin
         n_fail++;
         $display("FAIL halt_reset: halted=%b pc=%h, required 0/00", halted, pc);
      end
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      @(negedge clk);
      n_checks++;
      if (bus.in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL halt_reset_ready: in_ready=%b, required 1", bus.in_ready);
      end
   endtask

   task automatic test_abort();
      logic seen_wb;
      do_reset();
      bus.in_valid = 1'b1;
      bus.in_instr = 16'h8105;
      @(negedge clk);             // ISSUE
      bus.in_valid = 1'b0;
      @(negedge clk);             // CAPT
      rst_n = 1'b0;
      #1;
      seen_wb = bus.wb_valid;
      repeat (2) @(negedge clk) seen_wb |= bus.wb_valid;
      rst_n = 1'b1;
      model_reset();
      dbg_addr = 4'd1;
      @(negedge clk);
      seen_wb |= bus.wb_valid;
      n_checks++;
      if ({seen_wb, pc, dbg_data, bus.in_ready} !== {1'b0, 8'd0, 8'd0, 1'b1}) begin
         n_fail++;
         $display("FAIL abort_capt: wb_seen=%b pc=%h R1=%h ready=%b, required 0/00/00/1",
                  seen_wb, pc, dbg_data, bus.in_ready);
      end
   endtask

   task automatic test_random();
      txn_t o, e;
      logic [3:0] opc_tab [12];
      logic [15:0] instr;
      logic [3:0] a;
      opc_tab = '{4'h0, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'hB, 4'hD, 4'hE, 4'hF};
      do_reset();
      for (int i = 0; i < 60; i++) begin
         instr = {opc_tab[$urandom_range(0, 11)], 12'($urandom)};
         model_exec(instr, e);
         drive_instr(instr, o);
         n_checks++;
         if ({o.op1, o.op2, o.opcode, o.funct} !== {e.op1, e.op2, e.opcode, e.funct}) begin
            n_fail++;
            $display("FAIL rand_ops[%0d] %h: op1=%h op2=%h opc=%h fn=%h, required %h %h %h %h",
                     i, instr, o.op1, o.op2, o.opcode, o.funct, e.op1, e.op2, e.opcode, e.funct);
         end
         n_checks++;
         if ({o.ready_issue, o.ready_capt, o.wb_mid, o.wb_valid, o.pc, o.halted, o.ready_after} !==
             {2'b00, 1'b0, e.wb_valid, e.pc, e.halted, e.ready_after}) begin
            n_fail++;
            $display("FAIL rand_retire[%0d] %h: rdy=%b%b%b wb=%b pc=%h halted=%b, required 001 wb=%b pc=%h halted=%b",
                     i, instr, o.ready_issue, o.ready_capt, o.ready_after, o.wb_valid, o.pc, o.halted,
                     e.wb_valid, e.pc, e.halted);
         end
         if (e.wb_valid) begin
            n_checks++;
            if ({o.wb_addr, o.wb_data} !== {e.wb_addr, e.wb_data}) begin
               n_fail++;
               $display("FAIL rand_wb[%0d] %h: addr=%h data=%h, required %h %h",
                        i, instr, o.wb_addr, o.wb_data, e.wb_addr, e.wb_data);
            end
         end
         a = 4'($urandom_range(0, 15));
         dbg_addr = a;
         #1;
         n_checks++;
         if (dbg_data !== reg_m[a]) begin
            n_fail++;
            $display("FAIL rand_dbg[%0d] R%0d: got %h, required %h", i, a, dbg_data, reg_m[a]);
         end
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      bus.in_valid = 1'b0;
      bus.in_instr = 16'h0000;
      dbg_addr     = 4'd0;
      model_reset();
      test_reset();
      test_first_write();
      test_back_to_back();
      test_branch();
      test_r0_and_undefined();
      test_halt();
      test_abort();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Instruction issue and writeback sequencer that drives the team's registered 8-bit ALU. It accepts 16-bit instructions over a valid/ready handshake and decodes them into ALU `opcode`/`funct_code`/`op1`/`op2`. It reads operands from an internal 16x8 register file and captures the ALU `result`/`zero` one clock after issue. It then writes back the result or updates the program counter, and sits between the instruction source and the ALU.

## Interface
- No parameters. Fixed widths: instruction 16 bits, data 8 bits, 16 registers.
- `clk` in 1: single clock, rising edge. The ALU uses the same clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: instruction valid.
- `in_ready` out 1: block can accept an instruction.
- `in_instr` in 16: fields are [15:12] opcode, [11:8] rd, [7:4] rs, [3:0] funct/imm4.
- `alu_op1` out 8: to ALU `op1`. Registered.
- `alu_op2` out 8: to ALU `op2`. Registered.
- `alu_opcode` out 4: to ALU `opcode`. Registered.
- `alu_funct` out 4: to ALU `funct_code`. Registered.
- `alu_result` in 8: from ALU `result`.
- `alu_zero` in 1: from ALU `zero`.
- `wb_valid` out 1: one-cycle pulse when an instruction retires with a register write.
- `wb_addr` out 4: destination register of that write.
- `wb_data` out 8: value written.
- `pc` out 8: retired-instruction program counter.
- `halted` out 1: high once a halt instruction retires.
- `dbg_addr` in 4: debug read address.
- `dbg_data` out 8: combinational register-file read. R0 always reads 0.

## Operation
- States: IDLE, ISSUE, CAPT, HALT.
- **IDLE**
  - `in_ready`=1.
  - On `in_valid`: latch the instruction and load the ALU operand registers.
  - `alu_op1` = R[rd]. `alu_opcode` = instr[15:12]. `alu_funct` = instr[3:0].
  - `alu_op2` = R[rs] for type A (opcode 0000) and type C (01xx).
  - `alu_op2` = {4'h0, imm4} for type B (10xx).
  - `alu_op2` = 0 for type D (11xx).
  - Go to ISSUE.
- **ISSUE**: the ALU samples its operands at the end of this cycle. Go to CAPT.
- **CAPT**: `alu_result`/`alu_zero` are valid. At the end of this cycle the instruction retires:
  - Type A, and type B: R[rd] <= `alu_result`. Pulse `wb_valid` with `wb_addr`=rd, `wb_data`=`alu_result`. pc <= pc+1.
  - Type C: no writeback. If `alu_zero`=1, pc <= pc + sign_extend(imm4), range -8..+7. Otherwise pc <= pc+1.
  - Type D 1100: pc <= pc+1, then go to HALT.
  - Other type D opcodes: NOP, pc <= pc+1.
  - All retirements except halt return to IDLE.
- **HALT**: `in_ready`=0 and `halted`=1. Only reset exits.
- Writes to R0 are discarded. `wb_valid` still pulses with `wb_addr`=0.
- The full 8-bit `alu_result` is written. Nibble-width behaviour belongs to the ALU.
- Undefined ALU encodings (e.g. result 8'hEF) are written back unchanged for types A and B.
- pc arithmetic is modulo 256 and wraps 255->0. Branches below 0 wrap the same way.

## Timing
- Reset (asynchronous, immediate):
  - State IDLE.
  - `pc`=0, `halted`=0, `wb_valid`=0, `wb_addr`=0, `wb_data`=0.
  - `alu_op1`=0, `alu_op2`=0, `alu_opcode`=0, `alu_funct`=0.
  - All registers 0.
  - `in_ready`=1 from the first cycle after release.
- Accept at edge N. ALU samples at N+1. Retire (register write, `wb_valid`, pc update) at N+2. `in_ready` goes high again in the cycle after N+2.
- Throughput: one instruction per 3 cycles.
- `in_ready` is a registered function of state. It is 0 in ISSUE/CAPT/HALT, and `in_valid` is ignored there.
- Read-after-write needs no forwarding: the retire edge precedes the next accept.
- Reset asserted in ISSUE or CAPT aborts the instruction: no `wb_valid`, no pc change, no write.
- `dbg_data` reflects a write from the cycle after the retire edge.

## Test plan
- Reset, then `in_instr`=0x8105 -> at N+2 `wb_valid`=1, `wb_addr`=1, `wb_data`=0x05. `pc`=1. `dbg_addr`=1 reads 0x05.
- 0x8105, then 0x8203, then 0x012F (type A add R1,R2) -> third retire writes R1=0x08. `pc`=3. `in_ready` is low exactly 2 cycles per instruction.
- R1=5 and R2=5 via 0x8105 and 0x8205 (pc=2), then 0x612E (equal-compare, offset -2) -> ALU `zero`=1, no `wb_valid`, `pc`=0. Repeat with R2=3: `pc`=3.
- 0xC000 -> `pc` increments, `halted`=1, `in_ready` stays 0 for 20 cycles despite `in_valid`=1. `rst_n` low clears `halted`, `pc`=0.
- 0x8007 (rd=R0) -> `wb_valid`=1, `wb_addr`=0, `wb_data`=0x07. R0 still reads 0.
- Drive `rst_n` low during CAPT of 0x8105 -> no `wb_valid`. R1=0 and `pc`=0 after release.
